// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: serializer state encoding,
// frame constants and the even-parity helper used when the optional parity
// bit is built in (macro UART_TX_PARITY_EN, see uart_tx_fifo).
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // PARITY is only reachable when the parity option is compiled in; keeping
  // it in the enum gives both builds the same state encoding.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy count. The head entry is
// visible on dout combinationally so a reader can pop and use it on the
// same edge. Pushes while full and pops while empty are ignored.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (pointers and count only)
//   push   in   write request, honoured when not full
//   pop    in   read request, honoured when not empty
//   din    in   WIDTH-bit write data
//   dout   out  WIDTH-bit head entry
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  AW+1-bit occupancy
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the count guards every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Buffers bytes from a single-cycle write strobe in a small FIFO and
// serializes them as asynchronous frames (start, 8 data bits LSB first,
// stop) on a registered txd line. Back-to-back frames are contiguous.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frames).
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset; aborts any frame in flight
//   wr     in   write strobe; din captured when wr=1 and full=0
//   din    in   8-bit character
//   full   out  FIFO holds FIFO_DEPTH entries
//   empty  out  FIFO holds no entries
//   busy   out  serializer is not idle
//   ovf    out  sticky: a write was attempted while full (cleared by rst)
//   txd    out  serial line, idle high, driven from a flop
// ----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 104,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  output logic       txd
);

  localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           ovf_q;
  logic           baud_tick;
  logic           load;
  logic           pop;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_count_unused;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign baud_tick = (baud_q == BAUD_LAST);

  // --------------------------------------------------------------------------
  // Serializer next-state logic. txd_d is the level for the bit that starts
  // on this edge, so txd itself is a plain flop with no path from wr/din.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) begin
      baud_d = baud_tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end

      START: begin
        if (baud_tick) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end

      DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = STOP_BIT;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            txd_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          txd_d   = STOP_BIT;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = IDLE_LEVEL;
          end
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = IDLE_LEVEL;
      end
    endcase

    if (load) begin
      shift_d = fifo_dout;
      bit_d   = '0;
      baud_d  = '0;
      state_d = START;
      txd_d   = START_BIT;
`ifdef UART_TX_PARITY_EN
      par_d   = even_parity(fifo_dout);
`endif
    end
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Overflow is judged on the registered full flag, so a write on the same
  // edge as a pop from a full FIFO is still dropped and still flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wr && fifo_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign full  = fifo_full;
  assign empty = fifo_empty;
  assign busy  = (state_q != IDLE);
  assign ovf   = ovf_q;
  assign txd   = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo with BAUD_DIV=4, FIFO_DEPTH=8.
// A queue-and-frame model predicts txd/busy/empty/full/ovf every cycle; a
// line receiver decodes txd into bytes; directed sequences add hand-computed
// expectations. Build with UART_TX_PARITY_EN to cover the parity frame.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int BAUD  = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB        = 11;
  localparam int EXP_FRAME = 44;
`else
  localparam int FB        = 10;
  localparam int EXP_FRAME = 40;
`endif

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] din;
  logic       full, empty, busy, ovf, txd;

  uart_tx_fifo #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH),
    .AW         (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .din   (din),
    .full  (full),
    .empty (empty),
    .busy  (busy),
    .ovf   (ovf),
    .txd   (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line levels of one frame, index 0 = start bit; unused top bits are 1.
  function automatic logic [10:0] build_frame(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // ---------------- behavioural model (updated on each clock edge) ----------
  logic [7:0]  m_q[$];
  bit          m_active;
  int          m_pos;
  logic [10:0] m_frame;
  bit          m_ovf;
  int          m_sz;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_active = 0;
      m_pos    = 0;
      m_ovf    = 0;
    end else begin
      m_sz = m_q.size();
      if (m_active) begin
        m_pos++;
        if (m_pos == FB * BAUD) m_active = 0;
      end
      if (!m_active && m_sz != 0) begin
        m_frame  = build_frame(m_q.pop_front());
        m_pos    = 0;
        m_active = 1;
      end
      if (wr) begin
        if (m_sz == DEPTH) m_ovf = 1;
        else m_q.push_back(din);
      end
    end
  end

  // ---------------- per-cycle compare ----------------------------------------
  bit chk_en = 0;
  logic [4:0] exp_vec;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_vec = {m_active ? m_frame[m_pos / BAUD] : 1'b1, m_active,
                 m_q.size() == 0, m_q.size() == DEPTH, m_ovf};
      check("cycle {txd,busy,empty,full,ovf}", {txd, busy, empty, full, ovf}, exp_vec);
    end
  end

  // ---------------- line receiver ---------------------------------------------
  bit         rx_on = 0;
  int         rx_cnt;
  logic [7:0] rx_sh;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 0;
    end else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on  = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt > BAUD && rx_cnt < 9 * BAUD && (rx_cnt % BAUD) == BAUD / 2)
        rx_sh[(rx_cnt / BAUD) - 1] = txd;
`ifdef UART_TX_PARITY_EN
      if (rx_cnt == 9 * BAUD + BAUD / 2) check("rx_parity", txd, ^rx_sh);
`endif
      if (rx_cnt == (FB - 1) * BAUD + BAUD / 2) begin
        check("rx_stop", txd, 1);
        rx_log.push_back(rx_sh);
        rx_on = 0;
      end
    end
  end

  int busy_cnt = 0;
  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle within budget", n < budget, 1);
  endtask

  // ---------------- directed stimulus -----------------------------------------
  logic [10:0] exp41;
  logic [10:0] exp07;
  logic [7:0]  exp_rx [12];
  int          zeros;
  int          cyc;
  int          n;

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    din = 8'h00;
`ifdef UART_TX_PARITY_EN
    exp41 = 11'b10_01000001_0;
    exp07 = 11'b11_00000111_0;
`else
    exp41 = 11'b11_01000001_0;
    exp07 = 11'b11_00000111_0;
`endif
    exp_rx = '{8'h41, 8'h07, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
               8'h36, 8'h37, 8'h38, 8'h5A};

    // Pin the model's frame builder to hand-computed levels.
    check("model frame 41", build_frame(8'h41), exp41);
    check("model frame 07", build_frame(8'h07), exp07);

    // Reset held for 3 cycles.
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    check("reset txd", txd, 1);
    check("reset empty", empty, 1);
    check("reset full", full, 0);
    check("reset busy", busy, 0);
    check("reset ovf", ovf, 0);
    rst = 1'b0;

    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check("idle txd low cycles", zeros, 0);

    // Single byte 8'h41.
    busy_cnt = 0;
    wr = 1'b1; din = 8'h41;
    @(negedge clk);                    // edge k passed
    wr = 1'b0;
    check("k: empty", empty, 0);
    check("k: txd still idle", txd, 1);
    @(negedge clk);                    // edge k+1 passed, frame cycle 0
    check("k+1: txd start", txd, 0);
    check("k+1: busy", busy, 1);
    cyc = 0;
    for (int b = 0; b < FB; b++) begin
      while (cyc < BAUD * b + 1) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("41 bit %0d", b), txd, exp41[b]);
    end
    wait_idle(100);
    check("41 busy cycles", busy_cnt, EXP_FRAME);

    // Byte 8'h07 (parity bit 1 when enabled).
    busy_cnt = 0;
    wr = 1'b1; din = 8'h07;
    @(negedge clk);
    wr = 1'b0;
    repeat (2 + 9 * BAUD + 1) @(negedge clk);
    check("07 ninth level", txd, exp07[9]);
    wait_idle(100);
    check("07 busy cycles", busy_cnt, EXP_FRAME);

    // Burst of nine, overflow, then one more byte.
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; din = 8'h30 + 8'(i);
      @(negedge clk);
    end
    check("burst full", full, 1);
    check("burst ovf clear", ovf, 0);
    din = 8'hAA;
    @(negedge clk);
    wr = 1'b0;
    check("overflow ovf set", ovf, 1);
    n = 0;
    while (full === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("full drains within budget", n < 100, 1);
    wr = 1'b1; din = 8'h5A;
    @(negedge clk);
    wr = 1'b0;
    wait_idle(600);
    check("burst busy cycles", busy_cnt, 10 * EXP_FRAME);
    check("ovf sticky", ovf, 1);

    // Reset during data bit 3 of 8'h55 with four bytes queued.
    wr = 1'b1; din = 8'h55;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      din = 8'(i);
      @(negedge clk);
    end
    wr = 1'b0;                         // frame cycle 3
    repeat (14) @(negedge clk);        // frame cycle 17: data bit 3
    check("55 bit3 before reset", txd, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort txd", txd, 1);
    check("abort empty", empty, 1);
    check("abort busy", busy, 0);
    check("abort ovf cleared", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check("post-abort txd low cycles", zeros, 0);

    // Decoded byte stream.
    check("rx byte count", rx_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < rx_log.size()) check($sformatf("rx byte %0d", i), rx_log[i], exp_rx[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
